// File: rtl/hacd_cfg_regfile.sv
// HACD configuration/status register file: single-word req/resp slave in the cfg clock domain.
// Optional error capture (ERR_ADDR, INT_PEND[2], CTRL[3]) is built only when HACD_CFG_ERR_EN is defined.
module hacd_cfg_regfile #(
  parameter logic [31:0] HACD_ID   = 32'h4841_4344,
  parameter int unsigned EVT_CNT_W = 32
) (
  input  logic        cfg_clk_i,
  input  logic        cfg_rst_ni,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  output logic        resp_ready_o,
  output logic [31:0] resp_rdata_o,
  input  logic        infl_evt_i,
  input  logic        defl_evt_i,
  input  logic [15:0] status_i,
  output logic        ctrl_enable_o,
  output logic [3:0]  ctrl_mode_o,
  output logic [31:0] low_wm_o,
  output logic [31:0] high_wm_o,
  output logic [63:0] attr_base_o,
  output logic        infl_interrupt_o,
  output logic        defl_interrupt_o
);

  localparam logic [5:0] OFF_CTRL   = 6'h00;
  localparam logic [5:0] OFF_STATUS = 6'h01;
  localparam logic [5:0] OFF_PEND   = 6'h02;
  localparam logic [5:0] OFF_LOW    = 6'h03;
  localparam logic [5:0] OFF_HIGH   = 6'h04;
  localparam logic [5:0] OFF_ALO    = 6'h05;
  localparam logic [5:0] OFF_AHI    = 6'h06;
  localparam logic [5:0] OFF_EVT    = 6'h07;
  localparam logic [5:0] OFF_ID     = 6'h08;

`ifdef HACD_CFG_ERR_EN
  localparam logic [5:0] OFF_ERR   = 6'h09;
  localparam logic [5:0] OFF_LAST  = OFF_ERR;
  localparam int         PEND_W    = 3;
  localparam logic [7:0] CTRL_MASK = 8'hFF;
`else
  localparam logic [5:0] OFF_LAST  = OFF_ID;
  localparam int         PEND_W    = 2;
  localparam logic [7:0] CTRL_MASK = 8'hF7;
`endif

  logic [7:0]           ctrl_q;
  logic [PEND_W-1:0]    pend_q, pend_clr, pend_set;
  logic [31:0]          low_wm_q, high_wm_q, attr_lo_q, attr_hi_q;
  logic [EVT_CNT_W-1:0] evt_cnt_q;
  logic                 ready_q, infl_irq_q, defl_irq_q;
  logic [31:0]          rdata_mux;

  logic [5:0] offset;
  logic       in_page, mapped, accept, wr_en, cnt_inc, unmapped_acc;
  logic       unused_addr_lsb;

  assign offset          = req_addr_i[7:2];
  assign in_page         = (req_addr_i[31:8] == 24'd0);
  assign mapped          = in_page && (offset <= OFF_LAST);
  assign accept          = req_valid_i && ready_q;
  assign wr_en           = accept && req_write_i && mapped;
  assign unmapped_acc    = accept && !mapped;
  assign cnt_inc         = infl_evt_i && ctrl_q[0];
  assign unused_addr_lsb = ^req_addr_i[1:0];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

  // W1C clear and event set resolved so that a same-cycle event keeps the bit set.
  always_comb begin
    pend_clr = '0;
    if (wr_en && offset == OFF_PEND && req_wstrb_i[0]) begin
      pend_clr = req_wdata_i[PEND_W-1:0];
    end
    pend_set    = '0;
    pend_set[0] = infl_evt_i;
    pend_set[1] = defl_evt_i;
`ifdef HACD_CFG_ERR_EN
    pend_set[2] = unmapped_acc;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge cfg_clk_i or negedge cfg_rst_ni) begin
    if (!cfg_rst_ni) begin
      ready_q    <= 1'b0;
      ctrl_q     <= '0;
      pend_q     <= '0;
      low_wm_q   <= '0;
      high_wm_q  <= '0;
      attr_lo_q  <= '0;
      attr_hi_q  <= '0;
      evt_cnt_q  <= '0;
      infl_irq_q <= 1'b0;
      defl_irq_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (wr_en && offset == OFF_CTRL && req_wstrb_i[0]) ctrl_q <= req_wdata_i[7:0] & CTRL_MASK;
      if (wr_en && offset == OFF_LOW)  low_wm_q  <= merge_bytes(low_wm_q,  req_wdata_i, req_wstrb_i);
      if (wr_en && offset == OFF_HIGH) high_wm_q <= merge_bytes(high_wm_q, req_wdata_i, req_wstrb_i);
      if (wr_en && offset == OFF_ALO)  attr_lo_q <= merge_bytes(attr_lo_q, req_wdata_i, req_wstrb_i);
      if (wr_en && offset == OFF_AHI)  attr_hi_q <= merge_bytes(attr_hi_q, req_wdata_i, req_wstrb_i);
      pend_q <= (pend_q & ~pend_clr) | pend_set;

      // Any write clears the counter; a same-cycle increment restarts it at 1.
      if (wr_en && offset == OFF_EVT) begin
        evt_cnt_q <= EVT_CNT_W'(cnt_inc);
      end else if (cnt_inc && !(&evt_cnt_q)) begin
        evt_cnt_q <= evt_cnt_q + EVT_CNT_W'(1);
      end

      infl_irq_q <= pend_q[0] & ctrl_q[1];
`ifdef HACD_CFG_ERR_EN
      defl_irq_q <= (pend_q[1] & ctrl_q[2]) | (pend_q[2] & ctrl_q[3]);
`else
      defl_irq_q <= pend_q[1] & ctrl_q[2];
`endif
    end
  end

`ifdef HACD_CFG_ERR_EN
  logic [31:0] err_addr_q;

  // Capture only the first unmapped access since the error bit was last clear.
  always_ff @(posedge cfg_clk_i or negedge cfg_rst_ni) begin
    if (!cfg_rst_ni) begin
      err_addr_q <= '0;
    end else if (unmapped_acc && !pend_q[2]) begin
      err_addr_q <= req_addr_i;
    end
  end
`endif

  // NOTE: rdata_mux gets a default before the case so no latch is inferred for undecoded offsets.
  always_comb begin
    rdata_mux = '0;
    if (in_page) begin
      case (offset)
        OFF_CTRL:   rdata_mux[7:0]           = ctrl_q;
        OFF_STATUS: rdata_mux[15:0]          = status_i;
        OFF_PEND:   rdata_mux[PEND_W-1:0]    = pend_q;
        OFF_LOW:    rdata_mux                = low_wm_q;
        OFF_HIGH:   rdata_mux                = high_wm_q;
        OFF_ALO:    rdata_mux                = attr_lo_q;
        OFF_AHI:    rdata_mux                = attr_hi_q;
        OFF_EVT:    rdata_mux[EVT_CNT_W-1:0] = evt_cnt_q;
        OFF_ID:     rdata_mux                = HACD_ID;
`ifdef HACD_CFG_ERR_EN
        OFF_ERR:    rdata_mux                = err_addr_q;
`endif
        default:    rdata_mux                = '0;
      endcase
    end
  end

  assign resp_ready_o     = ready_q;
  assign resp_rdata_o     = (accept && !req_write_i) ? rdata_mux : 32'd0;
  assign ctrl_enable_o    = ctrl_q[0];
  assign ctrl_mode_o      = ctrl_q[7:4];
  assign low_wm_o         = low_wm_q;
  assign high_wm_o        = high_wm_q;
  assign attr_base_o      = {attr_hi_q, attr_lo_q};
  assign infl_interrupt_o = infl_irq_q;
  assign defl_interrupt_o = defl_irq_q;

endmodule
